fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue.sv | 173 +++++++++++++++++
 tb/tb_fetch_queue.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_queue
//  Purpose  : Instruction fetch unit with a small show-ahead queue. Issues
//             one-word reads to a fixed-latency (1 cycle) instruction memory,
//             buffers returned words with their addresses, and flushes on a
//             redirect from the core.
//  Ports    : clk          - clock, rising edge
//             reset        - asynchronous active-low reset
//             imem_req     - word read issued this cycle
//             imem_addr    - word address of the read
//             imem_rdata   - read data, valid one cycle after imem_req
//             redirect     - taken branch / call / return from the core
//             redirect_pc  - new fetch address when redirect=1
//             instr_valid  - queue head is presented
//             instr        - head instruction word
//             instr_pc     - word address of the head instruction
//             instr_ready  - core consumes the head this cycle
//             occupancy    - number of valid queue entries
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_queue #(
   parameter int              size     = 32,
   parameter int              DEPTH    = 4,
   parameter logic [size-1:0] RESET_PC = '0
) (
   input  logic                     clk,
   input  logic                     reset,
   output logic                     imem_req,
   output logic [size-1:0]          imem_addr,
   input  logic [size-1:0]          imem_rdata,
   input  logic                     redirect,
   input  logic [size-1:0]          redirect_pc,
   output logic                     instr_valid,
   output logic [size-1:0]          instr,
   output logic [size-1:0]          instr_pc,
   input  logic                     instr_ready,
   output logic [$clog2(DEPTH):0]   occupancy
);

   localparam int          c_ptr_w = $clog2(DEPTH);
   localparam int          c_cnt_w = c_ptr_w + 1;
   localparam logic [0:0]  c_boot  = 1'b0;
   localparam logic [0:0]  c_run   = 1'b1;

   logic [0:0]          state_q, state_d;
   logic                run;

   logic [size-1:0]     fetch_pc_q, fetch_pc_d;
   logic                inflight_q, inflight_d;
   logic [size-1:0]     inflight_pc_q, inflight_pc_d;
   logic [c_ptr_w-1:0]  wr_ptr_q, wr_ptr_d;
   logic [c_ptr_w-1:0]  rd_ptr_q, rd_ptr_d;
   logic [c_cnt_w-1:0]  count_q, count_d;

   logic [size-1:0]     instr_mem_q [DEPTH];
   logic [size-1:0]     pc_mem_q    [DEPTH];

   logic                push;
   logic                pop;
   logic [c_cnt_w:0]    reserved;

   // ------------------------------------------------------------------------
   // BOOT -> RUN sequencer
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= c_boot;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         c_boot:  state_d = c_run;
         c_run:   state_d = c_run;
         default: state_d = c_boot;
      endcase
   end

   always_comb begin
      run = (state_q == c_run);
   end

   // ------------------------------------------------------------------------
   // Request / push / pop decisions
   // ------------------------------------------------------------------------
   // A request reserves a slot for its returning word, so the queue can never
   // be asked to accept a push while full.
   assign reserved  = {1'b0, count_q} + {{c_cnt_w{1'b0}}, inflight_q};
   assign imem_req  = run && !redirect && (reserved < (c_cnt_w + 1)'(DEPTH));
   assign imem_addr = fetch_pc_q;

   // The word returning during a redirect belongs to the abandoned path.
   assign push = inflight_q && !redirect;
   assign pop  = instr_valid && instr_ready && !redirect;

   // ------------------------------------------------------------------------
   // Next-state for fetch pointer, inflight tracking and queue control
   // ------------------------------------------------------------------------
   always_comb begin
      fetch_pc_d    = fetch_pc_q;
      inflight_d    = inflight_q;
      inflight_pc_d = inflight_pc_q;
      wr_ptr_d      = wr_ptr_q;
      rd_ptr_d      = rd_ptr_q;
      count_d       = count_q;

      if (redirect) begin
         fetch_pc_d = redirect_pc;
         inflight_d = 1'b0;
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         count_d    = '0;
      end else begin
         if (push) begin
            wr_ptr_d = wr_ptr_q + c_ptr_w'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + c_ptr_w'(1);
         end
         case ({push, pop})
            2'b10:   count_d = count_q + c_cnt_w'(1);
            2'b01:   count_d = count_q - c_cnt_w'(1);
            default: count_d = count_q;
         endcase

         inflight_d = imem_req;
         if (imem_req) begin
            inflight_pc_d = fetch_pc_q;
            fetch_pc_d    = fetch_pc_q + size'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fetch_pc_q    <= RESET_PC;
         inflight_q    <= 1'b0;
         inflight_pc_q <= '0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         count_q       <= '0;
      end else begin
         fetch_pc_q    <= fetch_pc_d;
         inflight_q    <= inflight_d;
         inflight_pc_q <= inflight_pc_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         count_q       <= count_d;
      end
   end

   // Queue storage carries no reset: contents are qualified by count_q.
   always_ff @(posedge clk) begin
      if (push) begin
         instr_mem_q[wr_ptr_q] <= imem_rdata;
         pc_mem_q[wr_ptr_q]    <= inflight_pc_q;
      end
   end

   // ------------------------------------------------------------------------
   // Show-ahead head presentation
   // ------------------------------------------------------------------------
   assign instr_valid = (count_q != '0);
   assign instr       = instr_mem_q[rd_ptr_q];
   assign instr_pc    = pc_mem_q[rd_ptr_q];
   assign occupancy   = count_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_queue
//  Purpose  : Self-checking bench for fetch_queue. A queue-based reference
//             model predicts requests, addresses and the delivered
//             {instr, pc} stream; the bench also plays the instruction memory
//             (returns addr + 0x100 one cycle after each request).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_queue;

   localparam int              W  = 32;
   localparam int              D  = 4;
   localparam int              CW = $clog2(D) + 1;
   localparam logic [W-1:0]    RPC = 32'h0;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          imem_req;
   logic [W-1:0]  imem_addr;
   logic [W-1:0]  imem_rdata = '0;
   logic          redirect = 1'b0;
   logic [W-1:0]  redirect_pc = '0;
   logic          instr_valid;
   logic [W-1:0]  instr;
   logic [W-1:0]  instr_pc;
   logic          instr_ready = 1'b0;
   logic [CW-1:0] occupancy;

   always #5 clk = ~clk;

   fetch_queue #(
      .size     (W),
      .DEPTH    (D),
      .RESET_PC (RPC)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_rdata  (imem_rdata),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .instr_valid (instr_valid),
      .instr       (instr),
      .instr_pc    (instr_pc),
      .instr_ready (instr_ready),
      .occupancy   (occupancy)
   );

   int checks   = 0;
   int failures = 0;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // ------------------------------------------------------------------------
   // Reference model: architectural view of the fetch unit
   // ------------------------------------------------------------------------
   logic [W-1:0] m_pc_q[$];
   logic [W-1:0] m_ins_q[$];
   logic [W-1:0] m_fetch;
   bit           m_infl;
   logic [W-1:0] m_infl_pc;
   bit           m_run;

   task automatic model_reset();
      m_pc_q.delete();
      m_ins_q.delete();
      m_fetch   = RPC;
      m_infl    = 1'b0;
      m_infl_pc = '0;
      m_run     = 1'b0;
   endtask

   // One clock cycle: called just after a falling edge, returns at the next.
   task automatic step(input bit rd, input logic [W-1:0] rpc, input bit rdy);
      bit           exp_req;
      bit           req_seen;
      logic [W-1:0] addr_seen;
      redirect    = rd;
      redirect_pc = rpc;
      instr_ready = rdy;
      #1;
      exp_req = m_run && !rd && ((m_pc_q.size() + int'(m_infl)) < D);
      check_eq("imem_req", {63'b0, imem_req}, {63'b0, exp_req});
      if (exp_req) check_eq("imem_addr", {32'b0, imem_addr}, {32'b0, m_fetch});
      check_eq("occupancy", {{(64-CW){1'b0}}, occupancy}, 64'(m_pc_q.size()));
      check_eq("instr_valid", {63'b0, instr_valid}, {63'b0, (m_pc_q.size() != 0)});
      if (m_pc_q.size() != 0) begin
         check_eq("instr_pc", {32'b0, instr_pc}, {32'b0, m_pc_q[0]});
         check_eq("instr", {32'b0, instr}, {32'b0, m_ins_q[0]});
      end
      req_seen  = imem_req;
      addr_seen = imem_addr;

      if (rd) begin
         m_pc_q.delete();
         m_ins_q.delete();
         m_infl  = 1'b0;
         m_fetch = rpc;
      end else begin
         if (m_pc_q.size() != 0 && rdy) begin
            void'(m_pc_q.pop_front());
            void'(m_ins_q.pop_front());
         end
         if (m_infl) begin
            m_pc_q.push_back(m_infl_pc);
            m_ins_q.push_back(m_infl_pc + 32'h100);
         end
         m_infl = exp_req;
         if (exp_req) begin
            m_infl_pc = m_fetch;
            m_fetch   = m_fetch + 32'd1;
         end
      end
      m_run = 1'b1;

      @(posedge clk);
      #1;
      imem_rdata = req_seen ? (addr_seen + 32'h100) : $urandom;
      @(negedge clk);
   endtask

   initial begin
      model_reset();
      // Reset held: outputs forced idle.
      repeat (3) @(negedge clk);
      #1;
      check_eq("rst_req", {63'b0, imem_req}, 64'd0);
      check_eq("rst_valid", {63'b0, instr_valid}, 64'd0);
      check_eq("rst_occ", {{(64-CW){1'b0}}, occupancy}, 64'd0);
      @(negedge clk);
      reset = 1'b1;
      model_reset();

      // Streaming with the core always ready.
      repeat (20) step(1'b0, '0, 1'b1);

      // Core stalls: queue fills to DEPTH, requests stop.
      repeat (12) step(1'b0, '0, 1'b0);
      check_eq("sat_occ", {{(64-CW){1'b0}}, occupancy}, 64'(D));
      check_eq("sat_req", {63'b0, imem_req}, 64'd0);
      repeat (10) step(1'b0, '0, 1'b1);

      // Redirect while three entries are queued and one word is in flight.
      for (int i = 0; i < 12; i++) begin
         if (m_pc_q.size() == 3 && m_infl) break;
         step(1'b0, '0, 1'b0);
      end
      check_eq("pre_redir_occ", {{(64-CW){1'b0}}, occupancy}, 64'd3);
      step(1'b1, 32'h40, 1'b0);
      check_eq("redir_flush", {{(64-CW){1'b0}}, occupancy}, 64'd0);
      check_eq("redir_addr", {32'b0, imem_addr}, 64'h40);
      repeat (8) step(1'b0, '0, 1'b1);

      // Back-to-back redirects, then fetch across the address wrap.
      step(1'b1, 32'h1234, 1'b1);
      step(1'b1, 32'hFFFF_FFFE, 1'b1);
      repeat (8) step(1'b0, '0, 1'b1);

      // Asynchronous reset mid-stream with two entries queued.
      for (int i = 0; i < 12; i++) begin
         if (m_pc_q.size() == 2) break;
         step(1'b0, '0, 1'b0);
      end
      check_eq("pre_rst_occ", {{(64-CW){1'b0}}, occupancy}, 64'd2);
      #2;
      reset = 1'b0;
      #1;
      check_eq("arst_valid", {63'b0, instr_valid}, 64'd0);
      check_eq("arst_occ", {{(64-CW){1'b0}}, occupancy}, 64'd0);
      check_eq("arst_req", {63'b0, imem_req}, 64'd0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      model_reset();
      repeat (10) step(1'b0, '0, 1'b1);

      // Randomized traffic against the model.
      for (int i = 0; i < 10000; i++) begin
         bit           rd;
         bit           rdy;
         logic [W-1:0] rpc;
         rd  = ($urandom_range(0, 19) == 0);
         rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFF - 32'($urandom_range(0, 3))) : $urandom;
         rdy = ($urandom_range(0, 3) != 0);
         if ((i / 500) % 2 == 1) rdy = ($urandom_range(0, 3) == 0);
         step(rd, rpc, rdy);
         check_eq("occ_bound", {63'b0, (occupancy <= CW'(D))}, 64'd1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
